bidir_line_ctrl: RTL

Half-duplex single-wire transaction controller that drives the team's `gpio` bidirectional pad block from the fabric side. It serialises a command word onto the line with the pad in output mode, turns the line around, then deserialises a response word with the pad in input mode. It owns `dir`, the outgoing data bit and the sampled incoming bit of one `gpio` instance, and presents a start/done word interface to the host logic.

---
 rtl/bidir_line_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/bidir_line_ctrl.sv
// -----------------------------------------------------------------------------
// bidir_line_ctrl
//
// Half-duplex single-wire transaction controller driving one gpio pad from the
// fabric side. A transaction serialises a command word MSB-first with the pad
// in output mode, optionally releases the line for a turnaround gap and then
// deserialises a response word with the pad in input mode.
//
// Parameters
//   WIDTH        bits per transmitted / received word (>= 1)
//   CLK_DIV      clock cycles per line bit (>= 2)
//   TURN_CYCLES  released-line cycles between TX and RX (>= 1)
//
// Ports
//   clk_i      clock, all logic on rising edge
//   rst_i      synchronous active-high reset
//   start_i    start a transaction (accepted only while ready_o=1)
//   rx_en_i    sampled with start_i: 1 = TX then RX, 0 = TX only
//   tx_data_i  word to send, sampled with start_i
//   ready_o    controller idle
//   done_o     one-cycle pulse at transaction end
//   rx_data_o  last received word, valid from done_o onward
//   dir_o      to gpio dir_i: 1 = drive line, 0 = release
//   line_o     to gpio data_i: bit being driven
//   line_i     from gpio data_o: sampled line value
// -----------------------------------------------------------------------------
module bidir_line_ctrl #(
    parameter int WIDTH       = 8,
    parameter int CLK_DIV     = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             rx_en_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             dir_o,
    output logic             line_o,
    input  logic             line_i
);

    // Counter widths, at least one bit each.
    localparam int PW = (CLK_DIV     > 1) ? $clog2(CLK_DIV)     : 1;
    localparam int BW = (WIDTH       > 1) ? $clog2(WIDTH)       : 1;
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    localparam logic [PW-1:0] PER_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PER_SAMP  = PW'(CLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_TURN = 3'd2,
        S_RX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [PW-1:0]     r_per_cnt;
    logic [BW-1:0]     r_bit_cnt;
    logic [TW-1:0]     r_turn_cnt;
    logic [WIDTH-1:0]  r_tx_sh;
    logic [WIDTH-1:0]  r_rx_sh;
    logic              r_rx_en;
    logic [WIDTH-1:0]  r_rx_data;
    logic              r_ready;
    logic              r_done;
    logic              r_dir;
    logic              r_line;

    // Next-state values
    state_t            w_state_nx;
    logic [PW-1:0]     w_per_nx;
    logic [BW-1:0]     w_bit_nx;
    logic [TW-1:0]     w_turn_nx;
    logic [WIDTH-1:0]  w_tx_sh_nx;
    logic [WIDTH-1:0]  w_rx_sh_nx;
    logic              w_rx_en_nx;
    logic [WIDTH-1:0]  w_rx_data_nx;
    logic              w_per_end;
    logic              w_bit_end;

    assign w_per_end = (r_per_cnt == PER_LAST);
    assign w_bit_end = (r_bit_cnt == BIT_LAST);

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nx   = r_state;
        w_per_nx     = r_per_cnt;
        w_bit_nx     = r_bit_cnt;
        w_turn_nx    = r_turn_cnt;
        w_tx_sh_nx   = r_tx_sh;
        w_rx_sh_nx   = r_rx_sh;
        w_rx_en_nx   = r_rx_en;
        w_rx_data_nx = r_rx_data;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nx = S_TX;
                    w_tx_sh_nx = tx_data_i;
                    w_rx_en_nx = rx_en_i;
                    w_per_nx   = '0;
                    w_bit_nx   = '0;
                end
            end

            S_TX: begin
                if (w_per_end) begin
                    w_per_nx = '0;
                    if (w_bit_end) begin
                        w_bit_nx   = '0;
                        w_turn_nx  = '0;
                        w_state_nx = r_rx_en ? S_TURN : S_DONE;
                    end else begin
                        w_bit_nx   = r_bit_cnt + BW'(1);
                        w_tx_sh_nx = r_tx_sh << 1;
                    end
                end else begin
                    w_per_nx = r_per_cnt + PW'(1);
                end
            end

            S_TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    w_turn_nx  = '0;
                    w_per_nx   = '0;
                    w_bit_nx   = '0;
                    w_state_nx = S_RX;
                end else begin
                    w_turn_nx = r_turn_cnt + TW'(1);
                end
            end

            S_RX: begin
                // Mid-period sample absorbs the pad's one-cycle input delay.
                if (r_per_cnt == PER_SAMP)
                    w_rx_sh_nx = (r_rx_sh << 1) | WIDTH'(line_i);
                if (w_per_end) begin
                    w_per_nx = '0;
                    if (w_bit_end) begin
                        w_bit_nx     = '0;
                        w_state_nx   = S_DONE;
                        // With CLK_DIV=2 the last sample lands on this same
                        // cycle, so take the freshly shifted value.
                        w_rx_data_nx = w_rx_sh_nx;
                    end else begin
                        w_bit_nx = r_bit_cnt + BW'(1);
                    end
                end else begin
                    w_per_nx = r_per_cnt + PW'(1);
                end
            end

            S_DONE: begin
                w_state_nx = S_IDLE;
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. Outputs are derived from the next state so that they are
    // registered yet line up with the state they describe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_per_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_turn_cnt <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_en    <= 1'b0;
            r_rx_data  <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_dir      <= 1'b0;
            r_line     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_per_cnt  <= w_per_nx;
            r_bit_cnt  <= w_bit_nx;
            r_turn_cnt <= w_turn_nx;
            r_tx_sh    <= w_tx_sh_nx;
            r_rx_sh    <= w_rx_sh_nx;
            r_rx_en    <= w_rx_en_nx;
            r_rx_data  <= w_rx_data_nx;
            r_ready    <= (w_state_nx == S_IDLE);
            r_done     <= (w_state_nx == S_DONE);
            r_dir      <= (w_state_nx == S_TX);
            r_line     <= (w_state_nx == S_TX) ? w_tx_sh_nx[WIDTH-1] : 1'b0;
        end
    end

    assign ready_o   = r_ready;
    assign done_o    = r_done;
    assign rx_data_o = r_rx_data;
    assign dir_o     = r_dir;
    assign line_o    = r_line;

endmodule
